// File: rtl/writeback_cycle_pkg.sv
// writeback_cycle_pkg: shared widths, FSM states and result-source encodings
package writeback_cycle_pkg;
  localparam int DATA_W = 256;
  localparam int BEAT_W = 32;
  localparam int BEATS  = DATA_W / BEAT_W;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = $clog2(BEATS);
  typedef enum logic [1:0] {IDLE, WAIT_S, ASSEMBLE} state_e;
  localparam logic RES_ALU = 1'b0;
  localparam logic RES_MEM = 1'b1;
endpackage

// File: rtl/writeback_cycle_vec_beat_assembler.sv
// vec_beat_assembler: packs memory beats into one wide vector, lane 0 first
module vec_beat_assembler
  import writeback_cycle_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              beat_valid_i,
  input  logic [BEAT_W-1:0] beat_data_i,
  output logic              done_o,
  output logic [DATA_W-1:0] data_o
);
  logic [CNT_W-1:0]  cnt_q, cnt_d, idx;
  logic [DATA_W-1:0] lanes_q, lanes_d;
  // start clears the buffer and aims at lane 0 so a beat in the start cycle lands there
  always_comb begin
    idx = start_i ? '0 : cnt_q;
    lanes_d = start_i ? '0 : lanes_q;
    if (beat_valid_i) lanes_d[idx*BEAT_W +: BEAT_W] = beat_data_i;
    cnt_d = beat_valid_i ? idx + CNT_W'(1) : idx;
  end
  assign done_o = beat_valid_i && idx == CNT_W'(BEATS - 1);
  assign data_o = lanes_d;
  // lane buffer and beat counter; the counter wraps to 0 on the final beat
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q   <= '0;
      lanes_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      lanes_q <= lanes_d;
    end
endmodule

// File: rtl/writeback_cycle.sv
// writeback_cycle: final stage selecting ALU/load data and assembling vector loads
module writeback_cycle
  import writeback_cycle_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_m,
  input  logic              RegWriteM,
  input  logic              ResultSrcM,
  input  logic              VecM,
  input  logic [ADDR_W-1:0] RDM,
  input  logic [DATA_W-1:0] ALUResultM,
  input  logic [BEAT_W-1:0] ReadDataM,
  input  logic              beat_valid,
  output logic              RegWriteW,
  output logic [DATA_W-1:0] ResultW,
  output logic [ADDR_W-1:0] RDW,
  output logic              RegFileSelect,
  output logic              stall_o
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rd_q, rd_d, wr_rd;
  logic [DATA_W-1:0] wr_data, asm_data;
  logic              accept, load, vec_start, asm_beat, asm_done, wr, wr_vec, we;
  assign accept    = state_q == IDLE && valid_m && RegWriteM;
  assign load      = ResultSrcM == RES_MEM;
  assign vec_start = accept && load && VecM;
  assign asm_beat  = beat_valid && (vec_start || state_q == ASSEMBLE);
  assign stall_o   = state_q != IDLE;
  vec_beat_assembler u_asm (
    .clk          (clk),
    .rst_n        (rst),
    .start_i      (vec_start),
    .beat_valid_i (asm_beat),
    .beat_data_i  (ReadDataM),
    .done_o       (asm_done),
    .data_o       (asm_data)
  );
  // next state plus the write request and result mux for this cycle
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr      = 1'b0;
    wr_data = load ? DATA_W'(ReadDataM) : ALUResultM;
    wr_rd   = RDM;
    wr_vec  = VecM;
    case (state_q)
      IDLE: if (accept) begin
        if (!load || (!VecM && beat_valid)) wr = 1'b1;
        else begin
          rd_d    = RDM;
          state_d = VecM ? ASSEMBLE : WAIT_S;
        end
      end
      WAIT_S: if (beat_valid) begin
        wr      = 1'b1;
        wr_data = DATA_W'(ReadDataM);
        wr_rd   = rd_q;
        wr_vec  = 1'b0;
        state_d = IDLE;
      end
      ASSEMBLE: if (asm_done) begin
        wr      = 1'b1;
        wr_data = asm_data;
        wr_rd   = rd_q;
        wr_vec  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // scalar x0 is hardwired, so its writes are dropped; vector v0 is a real register
  assign we = wr && (wr_vec || wr_rd != '0);
  // state, latched destination and registered write port; data holds between pulses
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q       <= IDLE;
      rd_q          <= '0;
      RegWriteW     <= 1'b0;
      ResultW       <= '0;
      RDW           <= '0;
      RegFileSelect <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      RegWriteW <= we;
      if (we) begin
        ResultW       <= wr_data;
        RDW           <= wr_rd;
        RegFileSelect <= wr_vec;
      end
    end
endmodule

// File: tb/tb_writeback_cycle.sv
// tb_writeback_cycle: randomized self-checking bench with a transaction-level model
module tb_writeback_cycle;
  logic         clk = 1'b0, rst = 1'b0;
  logic         valid_m = 1'b0, RegWriteM = 1'b0, ResultSrcM = 1'b0, VecM = 1'b0, beat_valid = 1'b0;
  logic [4:0]   RDM = '0;
  logic [255:0] ALUResultM = '0;
  logic [31:0]  ReadDataM = '0;
  logic         RegWriteW, RegFileSelect, stall_o;
  logic [255:0] ResultW;
  logic [4:0]   RDW;
  int checks = 0, errors = 0;

  writeback_cycle dut (
    .clk(clk), .rst(rst), .valid_m(valid_m), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
    .VecM(VecM), .RDM(RDM), .ALUResultM(ALUResultM), .ReadDataM(ReadDataM), .beat_valid(beat_valid),
    .RegWriteW(RegWriteW), .ResultW(ResultW), .RDW(RDW), .RegFileSelect(RegFileSelect), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    valid_m = 0; RegWriteM = 0; ResultSrcM = 0; VecM = 0; beat_valid = 0;
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // drives one vector load; gaps[2i+:2] idle cycles precede beat i; noise pokes valid_m while stalled
  task automatic drive_vec(input logic [4:0] rd, input logic [255:0] bv, input logic [15:0] gaps,
                           input bit noise, output int early);
    early = 0;
    valid_m = 1; RegWriteM = 1; ResultSrcM = 1; VecM = 1; RDM = rd;
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < int'(gaps[2*i +: 2]); g++) begin
        beat_valid = 0;
        tick();
        early += int'(RegWriteW);
        valid_m = noise ? 1'($urandom) : 1'b0; ResultSrcM = 0; VecM = 0; RDM = 5'($urandom_range(1, 31));
        ALUResultM = rnd256();
      end
      beat_valid = 1; ReadDataM = bv[i*32 +: 32];
      tick();
      if (i < 7) early += int'(RegWriteW);
      valid_m = noise ? 1'($urandom) : 1'b0; ResultSrcM = 0; VecM = 0; RDM = 5'($urandom_range(1, 31));
      beat_valid = 0;
    end
    clr();
  endtask

  task automatic test_reset();
    rst = 0;
    tick(); tick();
    checks++; if ({RegWriteW, ResultW, RDW, RegFileSelect, stall_o} !== '0) begin errors++; $display("FAIL reset_outputs got we=%b rd=%0d sel=%b stall=%b res=%h", RegWriteW, RDW, RegFileSelect, stall_o, ResultW); end
    rst = 1;
    tick();
    checks++; if (stall_o !== 1'b0 || RegWriteW !== 1'b0) begin errors++; $display("FAIL reset_release got we=%b stall=%b want 0 0", RegWriteW, stall_o); end
  endtask

  task automatic test_alu();
    valid_m = 1; RegWriteM = 1; ResultSrcM = 0; VecM = 0; RDM = 5; ALUResultM = 256'h1234;
    tick();
    clr();
    checks++; if (RegWriteW !== 1'b1) begin errors++; $display("FAIL alu_we got %b want 1", RegWriteW); end
    checks++; if ({ResultW, RDW, RegFileSelect} !== {256'h1234, 5'd5, 1'b0}) begin errors++; $display("FAIL alu_data got res=%h rd=%0d sel=%b want 1234 5 0", ResultW, RDW, RegFileSelect); end
    tick();
    checks++; if (RegWriteW !== 1'b0) begin errors++; $display("FAIL alu_one_pulse got we=%b want 0", RegWriteW); end
  endtask

  task automatic test_scalar_load();
    logic [31:0] d;
    valid_m = 1; RegWriteM = 1; ResultSrcM = 1; VecM = 0; RDM = 7;
    for (int c = 0; c < 3; c++) begin
      tick();
      clr();
      checks++; if (stall_o !== 1'b1 || RegWriteW !== 1'b0) begin errors++; $display("FAIL sload_wait%0d got stall=%b we=%b want 1 0", c, stall_o, RegWriteW); end
    end
    beat_valid = 1; ReadDataM = 32'hDEADBEEF;
    tick();
    clr();
    checks++; if (RegWriteW !== 1'b1 || stall_o !== 1'b0) begin errors++; $display("FAIL sload_we got we=%b stall=%b want 1 0", RegWriteW, stall_o); end
    checks++; if ({ResultW, RDW, RegFileSelect} !== {256'hDEADBEEF, 5'd7, 1'b0}) begin errors++; $display("FAIL sload_data got res=%h rd=%0d sel=%b", ResultW, RDW, RegFileSelect); end
    d = $urandom;
    valid_m = 1; RegWriteM = 1; ResultSrcM = 1; VecM = 0; RDM = 9; beat_valid = 1; ReadDataM = d;
    tick();
    clr();
    checks++; if ({RegWriteW, stall_o, ResultW, RDW} !== {1'b1, 1'b0, {224'b0, d}, 5'd9}) begin errors++; $display("FAIL sload_same_cycle got we=%b stall=%b res=%h rd=%0d", RegWriteW, stall_o, ResultW, RDW); end
  endtask

  task automatic test_vector();
    logic [255:0] bv;
    int early;
    for (int i = 0; i < 8; i++) bv[i*32 +: 32] = {4{4'(i + 1)}} * 32'h1;
    bv = {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    drive_vec(5'd3, bv, 16'h1040, 1'b0, early);
    checks++; if (early !== 0) begin errors++; $display("FAIL vec_early got %0d pulses want 0", early); end
    checks++; if (RegWriteW !== 1'b1 || stall_o !== 1'b0) begin errors++; $display("FAIL vec_we got we=%b stall=%b want 1 0", RegWriteW, stall_o); end
    checks++; if (ResultW[31:0] !== 32'h11111111 || ResultW[255:224] !== 32'h88888888) begin errors++; $display("FAIL vec_lanes got lo=%h hi=%h", ResultW[31:0], ResultW[255:224]); end
    checks++; if ({ResultW, RDW, RegFileSelect} !== {bv, 5'd3, 1'b1}) begin errors++; $display("FAIL vec_data got res=%h rd=%0d sel=%b", ResultW, RDW, RegFileSelect); end
    tick();
    checks++; if (RegWriteW !== 1'b0) begin errors++; $display("FAIL vec_one_pulse got we=%b want 0", RegWriteW); end
  endtask

  task automatic test_reset_mid();
    logic [255:0] bv;
    int early;
    valid_m = 1; RegWriteM = 1; ResultSrcM = 1; VecM = 1; RDM = 12;
    for (int i = 0; i < 4; i++) begin
      beat_valid = 1; ReadDataM = $urandom;
      tick();
      valid_m = 0;
    end
    clr();
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL rmid_stall got %b want 1", stall_o); end
    rst = 0;
    #1;
    checks++; if ({RegWriteW, ResultW, RDW, RegFileSelect, stall_o} !== '0) begin errors++; $display("FAIL rmid_async got we=%b rd=%0d sel=%b stall=%b", RegWriteW, RDW, RegFileSelect, stall_o); end
    tick();
    rst = 1;
    tick();
    checks++; if (stall_o !== 1'b0 || RegWriteW !== 1'b0) begin errors++; $display("FAIL rmid_idle got stall=%b we=%b want 0 0", stall_o, RegWriteW); end
    bv = rnd256();
    drive_vec(5'd12, bv, 16'(($urandom) & 16'h5554), 1'b0, early);
    checks++; if (early !== 0 || RegWriteW !== 1'b1) begin errors++; $display("FAIL rmid_pulse got early=%0d we=%b want 0 1", early, RegWriteW); end
    checks++; if (ResultW !== bv || RDW !== 5'd12) begin errors++; $display("FAIL rmid_data got res=%h rd=%0d want %h 12", ResultW, RDW, bv); end
    tick();
    checks++; if (RegWriteW !== 1'b0) begin errors++; $display("FAIL rmid_one_pulse got we=%b want 0", RegWriteW); end
  endtask

  task automatic test_rd0();
    logic [255:0] a;
    a = rnd256();
    valid_m = 1; RegWriteM = 1; ResultSrcM = 0; VecM = 0; RDM = 0; ALUResultM = a;
    tick();
    clr();
    checks++; if (RegWriteW !== 1'b0) begin errors++; $display("FAIL rd0_scalar got we=%b want 0", RegWriteW); end
    valid_m = 1; RegWriteM = 1; ResultSrcM = 0; VecM = 1; RDM = 0;
    tick();
    clr();
    checks++; if ({RegWriteW, RegFileSelect, RDW, ResultW} !== {1'b1, 1'b1, 5'd0, a}) begin errors++; $display("FAIL rd0_vector got we=%b sel=%b rd=%0d res=%h", RegWriteW, RegFileSelect, RDW, ResultW); end
    valid_m = 1; RegWriteM = 1; ResultSrcM = 1; VecM = 0; RDM = 0; beat_valid = 1; ReadDataM = $urandom;
    tick();
    clr();
    checks++; if (RegWriteW !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("FAIL rd0_sload got we=%b stall=%b want 0 0", RegWriteW, stall_o); end
  endtask

  task automatic test_ignored();
    logic [255:0] bv;
    int early;
    for (int c = 0; c < 3; c++) begin
      beat_valid = 1; ReadDataM = $urandom;
      valid_m = c[0]; RegWriteM = 0; ResultSrcM = 1'($urandom); VecM = 1'($urandom); RDM = 5'($urandom_range(1, 31));
      tick();
      clr();
      checks++; if (RegWriteW !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("FAIL ign_idle%0d got we=%b stall=%b want 0 0", c, RegWriteW, stall_o); end
    end
    bv = rnd256();
    drive_vec(5'd20, bv, 16'h5555, 1'b1, early);
    checks++; if (early !== 0 || RegWriteW !== 1'b1) begin errors++; $display("FAIL ign_pulse got early=%0d we=%b want 0 1", early, RegWriteW); end
    checks++; if ({ResultW, RDW, RegFileSelect} !== {bv, 5'd20, 1'b1}) begin errors++; $display("FAIL ign_data got res=%h rd=%0d sel=%b", ResultW, RDW, RegFileSelect); end
  endtask

  task automatic test_back_to_back();
    logic [255:0] a;
    logic [4:0] rd;
    logic v;
    for (int k = 0; k < 6; k++) begin
      a = rnd256(); rd = 5'($urandom_range(1, 31)); v = 1'($urandom);
      valid_m = 1; RegWriteM = 1; ResultSrcM = 0; VecM = v; RDM = rd; ALUResultM = a;
      tick();
      checks++; if ({RegWriteW, ResultW, RDW, RegFileSelect} !== {1'b1, a, rd, v}) begin errors++; $display("FAIL b2b%0d got we=%b rd=%0d sel=%b res=%h", k, RegWriteW, RDW, RegFileSelect, ResultW); end
    end
    clr();
    tick();
  endtask

  task automatic test_random();
    logic [255:0] exp_d;
    logic [4:0] rd;
    logic v, exp_we;
    int kind, dly, early;
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 3);
      rd = 5'($urandom_range(0, 31)); v = 1'($urandom); early = 0;
      if (kind == 0) begin
        exp_d = rnd256(); exp_we = v || rd != 0;
        valid_m = 1; RegWriteM = 1; ResultSrcM = 0; VecM = v; RDM = rd; ALUResultM = exp_d;
        tick();
        clr();
      end else if (kind == 1) begin
        v = 0; exp_d = {224'b0, 32'($urandom)}; exp_we = rd != 0; dly = $urandom_range(0, 3);
        valid_m = 1; RegWriteM = 1; ResultSrcM = 1; VecM = 0; RDM = rd;
        for (int c = 0; c <= dly; c++) begin
          beat_valid = c == dly; ReadDataM = beat_valid ? exp_d[31:0] : 32'($urandom);
          tick();
          clr();
          if (c < dly) early += int'(RegWriteW);
        end
      end else if (kind == 2) begin
        v = 1; exp_d = rnd256(); exp_we = 1;
        drive_vec(rd, exp_d, 16'($urandom), 1'($urandom), early);
      end else begin
        exp_we = 0; exp_d = '0;
        valid_m = 1'($urandom); RegWriteM = 0; ResultSrcM = 1'($urandom); VecM = v; RDM = rd; beat_valid = 1'($urandom);
        tick();
        clr();
      end
      checks++; if (early !== 0 || RegWriteW !== exp_we || stall_o !== 1'b0) begin errors++; $display("FAIL rnd%0d_k%0d got we=%b early=%0d stall=%b want we=%b", n, kind, RegWriteW, early, stall_o, exp_we); end
      if (exp_we) begin
        checks++; if ({ResultW, RDW, RegFileSelect} !== {exp_d, rd, v}) begin errors++; $display("FAIL rnd%0d_k%0d_data got res=%h rd=%0d sel=%b want %h %0d %b", n, kind, ResultW, RDW, RegFileSelect, exp_d, rd, v); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_scalar_load();
    test_vector();
    test_reset_mid();
    test_rd0();
    test_ignored();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
